spi_master_tx: RTL and testbench

- SPI mode-0 master transmitter, MSB first, write-only (no MISO).
- Takes bytes from an internal valid/ready source and generates sck, cs and mosi for the design's SPI slave receiver.
- The receiver oversamples sck with the system clock through a 2-flop synchroniser, so sck runs at a programmable fraction of clk.
- Back-to-back bytes are sent in a burst under one cs assertion.

---
 rtl/spi_master_tx.sv | 143 ++++++++++++++
 tb/tb_spi_master_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 write-only master: MSB first, bursts back-to-back bytes under one
// cs frame. All outputs are registered; only the handshake looks at inputs.
module spi_master_tx #(
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 4,
  parameter int GAP_CYCLES = 4,
  parameter int CS_HOLD    = 4,
  parameter int CS_IDLE    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       cs,
  output logic       mosi
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP, HOLD, RELEASE} state_e;

  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
  localparam logic [7:0] GAP_M1   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);
  localparam logic [7:0] IDLE_M1  = 8'(CS_IDLE - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       tx_ready_q, tx_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sck_q, sck_d;
  logic       cs_q, cs_d;
  logic       mosi_q, mosi_d;

  logic hs, last;
  assign hs   = tx_valid & tx_ready_q;
  assign last = (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = last ? cnt_q : cnt_q - 8'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (hs) begin
        state_d = SETUP;
        cnt_d   = SETUP_M1;
        shreg_d = tx_data;
        mosi_d  = tx_data[7];
        bit_d   = 3'd0;
      end
      SETUP: if (last) begin
        state_d = LOW;
        cnt_d   = DIV_M1;
      end
      LOW: if (last) begin
        state_d = HIGH;
        cnt_d   = DIV_M1;
      end
      HIGH: if (last) begin
        if (bit_q == 3'd7) begin
          state_d = GAP;
          cnt_d   = GAP_M1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
        end else begin
          // next bit goes out on the same edge sck falls
          state_d = LOW;
          cnt_d   = DIV_M1;
          bit_d   = bit_q + 3'd1;
          shreg_d = {shreg_q[6:0], 1'b0};
          mosi_d  = shreg_q[6];
        end
      end
      GAP: if (last) begin
        if (hs) begin
          state_d = LOW;
          cnt_d   = DIV_M1;
          shreg_d = tx_data;
          mosi_d  = tx_data[7];
          bit_d   = 3'd0;
        end else begin
          state_d = HOLD;
          cnt_d   = HOLD_M1;
        end
      end
      HOLD: if (last) begin
        state_d = RELEASE;
        cnt_d   = IDLE_M1;
      end
      RELEASE: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // outputs follow the state being entered so they line up with it
    sck_d      = (state_d == HIGH);
    cs_d       = (state_d inside {IDLE, RELEASE});
    busy_d     = (state_d != IDLE);
    tx_ready_d = (state_d == IDLE) || (state_d == GAP && cnt_d == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'd0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sck      = sck_q;
  assign cs       = cs_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: three divider instances, a waveform model derived
// from the timing rules, and a sampling SPI slave collecting received bytes.
module tb_spi_master_tx;
  localparam int S = 4, G = 4, H = 4, I = 2;
  localparam int DIVS [3] = '{4, 2, 255};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0][7:0] tx_data = '0;
  logic [2:0] tx_valid = '0;
  logic [2:0] tx_ready, busy, done, sck, cs, mosi;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_master_tx #(.CLK_DIV(g == 0 ? 4 : (g == 1 ? 2 : 255))) u_dut (
      .clk(clk), .reset(reset), .tx_data(tx_data[g]), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .busy(busy[g]), .done(done[g]), .sck(sck[g]),
      .cs(cs[g]), .mosi(mosi[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  logic mon_en = 1'b0;
  logic [7:0] bq [8];

  // slave-side observation state
  int dones [3], frames [3], rises [3], rxn [3], nbits [3];
  int cs_run [3], sck_run [3], last_cs_lo [3], last_cs_hi [3];
  int hi_bad [3], lo_bad [3], age_bad [3], mosi_age [3];
  int firstlo [3][32];
  logic [7:0] bits [3];
  logic [7:0] rxb [3][32];
  logic prev_cs [3], prev_sck [3], prev_mosi [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; prev_mosi[i] = 1'b0; bits[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < 3; i++) begin
          if (done[i]) dones[i]++;
          if (mosi[i] != prev_mosi[i]) mosi_age[i] = 0; else mosi_age[i]++;
          if (cs[i] != prev_cs[i]) begin
            if (cs[i]) begin last_cs_lo[i] = cs_run[i]; nbits[i] = 0; end
            else begin last_cs_hi[i] = cs_run[i]; frames[i]++; end
            cs_run[i] = 1;
          end else cs_run[i]++;
          if (sck[i] && !prev_sck[i]) begin
            rises[i]++;
            if (mosi_age[i] < DIVS[i]) age_bad[i]++;
            if (nbits[i] == 0) firstlo[i][rxn[i]] = sck_run[i];
            else if (sck_run[i] != DIVS[i]) lo_bad[i]++;
            bits[i] = {bits[i][6:0], mosi[i]};
            nbits[i]++;
            if (nbits[i] == 8) begin
              if (rxn[i] < 31) begin rxb[i][rxn[i]] = bits[i]; rxn[i]++; end
              nbits[i] = 0;
            end
            sck_run[i] = 1;
          end else if (!sck[i] && prev_sck[i]) begin
            if (!cs[i] && sck_run[i] != DIVS[i]) hi_bad[i]++;
            sck_run[i] = 1;
          end else sck_run[i]++;
          if (!cs[i] && prev_cs[i]) sck_run[i] = 1;
          prev_cs[i] = cs[i]; prev_sck[i] = sck[i]; prev_mosi[i] = mosi[i];
        end
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] obs(input int i);
    return {cs[i], sck[i], mosi[i], done[i], busy[i], tx_ready[i]};
  endfunction

  // {cs, sck, mosi, done, busy, tx_ready} t cycles after a lone handshake
  function automatic logic [5:0] exp_wave(input int t, input logic [7:0] b, input int d);
    int fall8, csr, rdy, k;
    logic cs_e, sck_e, mosi_e, done_e, busy_e, rdy_e;
    fall8  = 1 + S + 16 * d;
    csr    = fall8 + G + H;
    rdy    = csr + I;
    cs_e   = !(t >= 1 && t < csr);
    sck_e  = (t >= 1 + S) && (t < fall8) && (((t - 1 - S) % (2 * d)) >= d);
    mosi_e = 1'b0;
    if (t >= 1 && t < fall8) begin
      k = (t < 1 + S) ? 0 : (t - 1 - S) / (2 * d);
      mosi_e = b[7 - k];
    end
    done_e = (t == fall8);
    busy_e = (t >= 1 && t < rdy);
    rdy_e  = (t == fall8 + G - 1) || (t >= rdy);
    return {cs_e, sck_e, mosi_e, done_e, busy_e, rdy_e};
  endfunction

  task automatic send(input int i, input logic [7:0] b, output int hcyc);
    int n;
    n = 0;
    tx_data[i] = b;
    tx_valid[i] = 1'b1;
    while (tx_ready[i] !== 1'b1 && n < 10000) begin @(negedge clk); n++; end
    chk("hs_timeout", int'(n < 10000), 1);
    @(posedge clk); #1;
    hcyc = cyc;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy[i] !== 1'b0 && n < 10000);
    chk("idle_timeout", int'(n < 10000), 1);
    #1;
  endtask

  task automatic check_byte(input int i, input logic [7:0] b, input bit noisy);
    int h, bx, bd, br, d, tend;
    logic [5:0] e;
    d = DIVS[i];
    bx = rxn[i]; bd = dones[i]; br = rises[i];
    send(i, b, h);
    tx_valid[i] = 1'b0;
    tend = 1 + S + 16 * d + G + H + I;
    for (int t = 1; t <= tend + 1; t++) begin
      @(negedge clk);
      e = exp_wave(t, b, d);
      chk($sformatf("wave%0d_t%0d", i, t), int'(obs(i)), int'(e));
      tx_data[i] = 8'($urandom);
      tx_valid[i] = (noisy && !e[0] && t < tend - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    #1;
    chk("rx_count", rxn[i] - bx, 1);
    chk("rx_byte", int'(rxb[i][bx]), int'(b));
    chk("done_count", dones[i] - bd, 1);
    chk("rise_count", rises[i] - br, 8);
    chk("cs_low_len", last_cs_lo[i], S + 16 * d + G + H);
    chk("setup_low", firstlo[i][bx], S + d);
  endtask

  task automatic burst(input int n);
    int h, hp, bx, bd, br, bf, d;
    d = DIVS[0];
    bx = rxn[0]; bd = dones[0]; br = rises[0]; bf = frames[0];
    send(0, bq[0], hp);
    for (int k = 1; k < n; k++) begin
      send(0, bq[k], h);
      chk("burst_hs_gap", h - hp, (k == 1 ? S : 0) + 16 * d + G);
      hp = h;
    end
    tx_valid[0] = 1'b0;
    wait_idle(0);
    chk("burst_frames", frames[0] - bf, 1);
    chk("burst_rises", rises[0] - br, 8 * n);
    chk("burst_dones", dones[0] - bd, n);
    chk("burst_cs_low", last_cs_lo[0], S + n * (16 * d + G) + H);
    chk("burst_rx_count", rxn[0] - bx, n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("burst_byte%0d", k), int'(rxb[0][bx + k]), int'(bq[k]));
      chk($sformatf("burst_lead_low%0d", k), firstlo[0][bx + k], (k == 0 ? S : G) + d);
    end
  endtask

  task automatic late_valid();
    int h0, h1, bx, bf;
    bx = rxn[0]; bf = frames[0];
    send(0, 8'h42, h0);
    tx_valid[0] = 1'b0;
    while (cyc < h0 + 74) @(negedge clk);
    send(0, 8'h81, h1);
    tx_valid[0] = 1'b0;
    chk("late_hs_cycle", h1 - h0, S + 16 * DIVS[0] + G + H + I + 1);
    wait_idle(0);
    chk("late_frames", frames[0] - bf, 2);
    chk("late_cs_idle", int'(last_cs_hi[0] >= I), 1);
    chk("late_rx0", int'(rxb[0][bx]), 8'h42);
    chk("late_rx1", int'(rxb[0][bx + 1]), 8'h81);
    chk("late_setup", firstlo[0][bx + 1], S + DIVS[0]);
  endtask

  task automatic reset_mid();
    int h, bx, bd, br;
    bx = rxn[0]; bd = dones[0]; br = rises[0];
    send(0, 8'hF0, h);
    tx_valid[0] = 1'b0;
    while (cyc < h + 33) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_out", int'(obs(0)), 6'b100000);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_rdy", int'(tx_ready[0]), 1);
    #1;
    chk("rst_mid_rx", rxn[0] - bx, 0);
    chk("rst_mid_done", dones[0] - bd, 0);
    chk("rst_mid_rises", rises[0] - br, 4);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_state%0d", i), int'(obs(i)), 6'b100000);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("rdy_after_rst%0d", i), int'(tx_ready[i]), 1);
    mon_en = 1'b1;
    #1;
    check_byte(0, 8'hA5, 1'b0);
    repeat (3) check_byte(0, 8'($urandom), 1'b1);
    bq[0] = 8'h3C; bq[1] = 8'hFF; bq[2] = 8'h00;
    burst(3);
    for (int k = 0; k < 4; k++) bq[k] = 8'($urandom);
    burst(4);
    late_valid();
    reset_mid();
    check_byte(0, 8'h55, 1'b0);
    check_byte(1, 8'h96, 1'b0);
    check_byte(2, 8'h96, 1'b0);
    check_byte(1, 8'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sck_high_width%0d", i), hi_bad[i], 0);
      chk($sformatf("sck_low_width%0d", i), lo_bad[i], 0);
      chk($sformatf("mosi_stable%0d", i), age_bad[i], 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
